serial_adder_ctrl: RTL

Bit-serial adder wrapper that loads two WIDTH-bit operands and a carry-in, then steps them LSB-first through a one-bit full-adder cell, one bit per clock. A registered carry feeds back between bits. The block sits directly upstream of the single-bit full adder and turns it into a multi-bit adder with a start/busy/done handshake, so the team gets small-area multi-bit addition from the existing one-bit cell.

---
 rtl/serial_adder_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: loads A/B/Cin on start, then pushes one bit
// per clock (LSB first) through a full-adder cell with a registered carry.
// S/Cout are published only on entry to DONE and otherwise hold.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_nx;
    logic             c, sum_bit, carry, last;
    logic [CW-1:0]    count;

    // Full-adder cell on the current LSBs; next sum register has the new bit at the MSB
    always_comb begin
        sum_bit        = a_sh[0] ^ b_sh[0] ^ c;
        carry          = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        s_nx           = s_sh >> 1;
        s_nx[WIDTH-1]  = sum_bit;
        last           = (count == CW'(WIDTH - 1));
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic: start only matters in IDLE, DONE always lasts one cycle
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (last)  state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: operand capture, bit stepping, and result publish on the final bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            s_sh  <= '0;
            c     <= 1'b0;
            count <= '0;
            S     <= '0;
            Cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= A;
                        b_sh  <= B;
                        c     <= Cin;
                        count <= '0;
                    end
                end
                SHIFT: begin
                    s_sh  <= s_nx;
                    c     <= carry;
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    count <= count + CW'(1);
                    if (last) begin
                        S    <= s_nx;
                        Cout <= carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule
